// File: rtl/serial_match_scheduler_pkg.sv
// Shared types for the serial match scheduler: detector and scheduler state encodings.
package serial_match_scheduler_pkg;

    localparam int unsigned DEFAULT_W = 8;

    typedef enum logic [1:0] {
        A = 2'd0,
        B = 2'd1,
        C = 2'd2,
        D = 2'd3
    } det_state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } sched_state_t;

endpackage

// File: rtl/seq_detector.sv
// Serial Mealy "1-then-0" detector; y pulses on each 1->0 transition of x while enabled.
module seq_detector
    import serial_match_scheduler_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic y
);

    det_state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = A;
        end else if (en) begin
            unique case (state_q)
                A:       state_d = x ? B : A;
                B:       state_d = x ? D : A;
                C:       state_d = x ? C : A;
                D:       state_d = x ? C : A;
                default: state_d = A;
            endcase
        end
    end

    // Any state other than A means the previous bit was a 1.
    assign y = en & ~x & (state_q != A);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= A;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/serial_match_scheduler.sv
// Round-robin scheduler that shares one serial 1-then-0 detector between two word requesters.
module serial_match_scheduler
    import serial_match_scheduler_pkg::*;
#(
    parameter int unsigned W  = DEFAULT_W,
    parameter int unsigned CW = $clog2(W / 2 + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [W-1:0]  data0,
    input  logic [W-1:0]  data1,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic          bit_x,
    output logic          hit_y,
    output logic          done,
    output logic          done_id,
    output logic [CW-1:0] match_cnt
);

    localparam int unsigned BW = (W > 2) ? $clog2(W) : 1;

    sched_state_t  state_q, state_d;
    logic [W-1:0]  sreg_q, sreg_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [CW-1:0] count_q, count_d;
    logic          owner_q, owner_d;
    logic          last_id_q, last_id_d;
    logic          winner;
    logic          shifting;
    logic          det_clr;

    // On a tie the requester that was not served last wins.
    assign winner   = (req == 2'b11) ? ~last_id_q : req[1];
    assign shifting = (state_q == SHIFT);

    always_comb begin
        gnt = 2'b00;
        if (reset && state_q == IDLE && req != 2'b00) begin
            gnt = winner ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bcnt_d    = bcnt_q;
        count_d   = count_q;
        owner_d   = owner_q;
        last_id_d = last_id_q;
        det_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    sreg_d    = winner ? data1 : data0;
                    owner_d   = winner;
                    last_id_d = winner;
                    bcnt_d    = '0;
                    count_d   = '0;
                    det_clr   = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d  = sreg_q >> 1;
                count_d = count_q + {{(CW - 1){1'b0}}, hit_y};
                bcnt_d  = bcnt_q + 1'b1;
                if (bcnt_q == BW'(W - 1)) begin
                    state_d = REPORT;
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            bcnt_q    <= '0;
            count_q   <= '0;
            owner_q   <= 1'b0;
            last_id_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bcnt_q    <= bcnt_d;
            count_q   <= count_d;
            owner_q   <= owner_d;
            last_id_q <= last_id_d;
        end
    end

    seq_detector u_det (
        .clk   (clk),
        .reset (reset),
        .clr   (det_clr),
        .en    (shifting),
        .x     (sreg_q[0]),
        .y     (hit_y)
    );

    assign busy      = (state_q != IDLE);
    assign bit_x     = shifting & sreg_q[0];
    assign done      = (state_q == REPORT);
    // Count and owner stay registered from capture until the next capture.
    assign done_id   = owner_q;
    assign match_cnt = count_q;

endmodule

// File: tb/tb_serial_match_scheduler.sv
// Directed plus randomized bench for serial_match_scheduler against a word-level reference model.
module tb_serial_match_scheduler;

    localparam int W  = 8;
    localparam int CW = $clog2(W / 2 + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [W-1:0]  data0;
    logic [W-1:0]  data1;
    logic [1:0]    gnt;
    logic          busy;
    logic          bit_x;
    logic          hit_y;
    logic          done;
    logic          done_id;
    logic [CW-1:0] match_cnt;

    int   checks = 0;
    int   errors = 0;
    logic m_last_id;

    always #5 clk = ~clk;

    serial_match_scheduler #(
        .W  (W),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .gnt       (gnt),
        .busy      (busy),
        .bit_x     (bit_x),
        .hit_y     (hit_y),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: one hit for every 1 followed (in LSB-first order) by a 0.
    function automatic int ref_hits(input logic [W-1:0] w);
        int n = 0;
        for (int i = 1; i < W; i++) begin
            if (w[i-1] == 1'b1 && w[i] == 1'b0) n++;
        end
        return n;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_bit_x"}, 32'(bit_x), 0);
        chk({tag, "_hit_y"}, 32'(hit_y), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_done_id"}, 32'(done_id), 0);
        chk({tag, "_match_cnt"}, 32'(match_cnt), 0);
    endtask

    // Starts at posedge+1 of an IDLE cycle; ends at posedge+1 of cycle W+2.
    task automatic run_job(input logic [1:0] r, input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input int drop_at, input logic [1:0] rep_req);
        logic         win;
        logic [W-1:0] w;
        logic         exp_hit;
        int           exp_cnt;
        req   = r;
        data0 = d0;
        data1 = d1;
        win   = (r == 2'b11) ? ~m_last_id : r[1];
        w     = win ? d1 : d0;
        m_last_id = win;
        exp_cnt   = ref_hits(w);
        @(negedge clk);
        chk("gnt_cycle0", 32'(gnt), win ? 32'd2 : 32'd1);
        chk("busy_cycle0", 32'(busy), 0);
        chk("done_cycle0", 32'(done), 0);
        for (int k = 1; k <= W; k++) begin
            @(posedge clk);
            #1;
            if (k == drop_at) req = 2'b00;
            exp_hit = 1'b0;
            if (k > 1) exp_hit = w[k-2] & ~w[k-1];
            @(negedge clk);
            chk("bit_x", 32'(bit_x), 32'(w[k-1]));
            chk("hit_y", 32'(hit_y), 32'(exp_hit));
            chk("busy_shift", 32'(busy), 1);
            chk("gnt_shift", 32'(gnt), 0);
            chk("done_shift", 32'(done), 0);
        end
        @(posedge clk);
        #1;
        req = rep_req;
        @(negedge clk);
        chk("done_report", 32'(done), 1);
        chk("done_id", 32'(done_id), 32'(win));
        chk("match_cnt", 32'(match_cnt), 32'(exp_cnt));
        chk("gnt_report", 32'(gnt), 0);
        chk("busy_report", 32'(busy), 1);
        chk("bit_x_report", 32'(bit_x), 0);
        chk("hit_y_report", 32'(hit_y), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] r;
        reset     = 1'b0;
        req       = 2'b01;
        data0     = '0;
        data1     = '0;
        m_last_id = 1'b1;

        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        req   = 2'b00;
        @(negedge clk);
        chk("idle_no_req_gnt", 32'(gnt), 0);
        chk("idle_no_req_busy", 32'(busy), 0);
        @(posedge clk);
        #1;

        // Tie held from reset: grants alternate 0,1,0, each W+2 cycles apart.
        for (int j = 0; j < 3; j++) begin
            run_job(2'b11, W'($urandom), W'($urandom), 0, 2'b11);
        end

        run_job(2'b01, 8'h55, 8'h00, 0, 2'b00);
        run_job(2'b10, 8'h00, 8'hFF, 0, 2'b00);
        run_job(2'b10, 8'h00, 8'h80, 0, 2'b00);
        run_job(2'b10, 8'h00, 8'h06, 0, 2'b00);

        // req dropped mid-job; job still completes.
        run_job(2'b01, 8'h00, 8'hFF, 3, 2'b00);

        // Request raised during REPORT is granted in the following IDLE cycle.
        run_job(2'b10, W'($urandom), W'($urandom), 0, 2'b01);
        run_job(2'b01, W'($urandom), W'($urandom), 0, 2'b00);

        for (int j = 0; j < 8; j++) begin
            r = 2'($urandom_range(1, 3));
            run_job(r, W'($urandom), W'($urandom), 0, ($urandom_range(0, 1) == 1) ? r : 2'b00);
        end

        // Abort mid-SHIFT with reset.
        req   = 2'b01;
        data0 = 8'hA5;
        @(negedge clk);
        chk("abort_gnt", 32'(gnt), 1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done), 0);
        chk("abort_busy", 32'(busy), 0);
        reset     = 1'b1;
        m_last_id = 1'b1;
        // Leading 0 must not hit: detector restarts from A.
        run_job(2'b01, 8'h54, 8'h00, 0, 2'b00);

        // Second reset then a tie: last_id is back to 1, so requester 0 wins.
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        m_last_id = 1'b1;
        run_job(2'b11, W'($urandom), W'($urandom), 0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
